// File: rtl/rf_multiport_if.sv
// Bundle of the register-file clear, write and read signals.
// The master side is the datapath and the slave side is the register file.
interface rf_multiport_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              clr_req;
    logic              rf_ready;
    logic              rf_wen0;
    logic [ADDR_W-1:0] rf_addr_w0;
    logic [DATA_W-1:0] rf_data_w0;
    logic              rf_wen1;
    logic [ADDR_W-1:0] rf_addr_w1;
    logic [DATA_W-1:0] rf_data_w1;
    logic [ADDR_W-1:0] rf_addr_r1;
    logic [ADDR_W-1:0] rf_addr_r2;
    logic [DATA_W-1:0] rf_data_r1;
    logic [DATA_W-1:0] rf_data_r2;

    modport master (
        output clr_req, rf_wen0, rf_addr_w0, rf_data_w0,
               rf_wen1, rf_addr_w1, rf_data_w1, rf_addr_r1, rf_addr_r2,
        input  rf_ready, rf_data_r1, rf_data_r2
    );

    modport slave (
        input  clr_req, rf_wen0, rf_addr_w0, rf_data_w0,
               rf_wen1, rf_addr_w1, rf_data_w1, rf_addr_r1, rf_addr_r2,
        output rf_ready, rf_data_r1, rf_data_r2
    );
endinterface

// File: rtl/rf_multiport.sv
// Multi-port register file: two combinational read ports and two write ports.
// Write port 1 has priority over write port 0 on a shared address.
// Entry 0 can optionally be hardwired to zero.
// Write-to-read bypass is optional.
// Storage carries no per-bit reset. Instead, a sweep engine clears one entry
// per cycle after reset or when a clear is requested.
module rf_multiport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input logic           clk,
    input logic           rst,
    rf_multiport_if.slave rf
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] IDX_ONE  = (ADDR_W + 1)'(1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   clr_idx_q, clr_idx_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              we0_s, we1_s;
    logic [DATA_W-1:0] rd1_s, rd2_s;

    // Resolve one read port.
    // The port reads 0 while clearing and also reads 0 for hardwired entry 0.
    // Otherwise it returns bypassed write data (port 1 first), or the stored entry.
    function automatic logic [DATA_W-1:0] read_sel(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              ready,
        input logic              w0,
        input logic [ADDR_W-1:0] a0,
        input logic [DATA_W-1:0] d0,
        input logic              w1,
        input logic [ADDR_W-1:0] a1,
        input logic [DATA_W-1:0] d1
    );
        logic [DATA_W-1:0] r;
        if (!ready) begin
            r = '0;
        end else if (ZERO_REG && (addr == '0)) begin
            r = '0;
        end else if (BYPASS && w1 && (a1 == addr)) begin
            r = d1;
        end else if (BYPASS && w0 && (a0 == addr)) begin
            r = d0;
        end else begin
            r = stored;
        end
        return r;
    endfunction

    // Effective write enables: only in READY, and never to a hardwired entry 0.
    assign we0_s = (state_q == ST_READY) && rf.rf_wen0 &&
                   !(ZERO_REG && (rf.rf_addr_w0 == '0));
    assign we1_s = (state_q == ST_READY) && rf.rf_wen1 &&
                   !(ZERO_REG && (rf.rf_addr_w1 == '0));

    // Sweep/ready next-state logic.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        ready_d   = ready_q;
        case (state_q)
            ST_CLEAR: begin
                clr_idx_d = clr_idx_q + IDX_ONE;
                if (clr_idx_q == LAST_IDX) begin
                    state_d = ST_READY;
                    ready_d = 1'b1;
                end else begin
                    ready_d = 1'b0;
                end
            end
            ST_READY: begin
                if (rf.clr_req) begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = '0;
                    ready_d   = 1'b0;
                end else begin
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_idx_d = '0;
                ready_d   = 1'b0;
            end
        endcase
    end

    // State, sweep index and ready flag registers; reset restarts the sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            ready_q   <= ready_d;
        end
    end

    // Storage update.
    // The sweep clears one entry per cycle.
    // Otherwise port 0 writes, then port 1 writes, so port 1 wins a shared address.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_CLEAR) begin
                mem_q[clr_idx_q[ADDR_W-1:0]] <= '0;
            end else begin
                if (we0_s) begin
                    mem_q[rf.rf_addr_w0] <= rf.rf_data_w0;
                end
                if (we1_s) begin
                    mem_q[rf.rf_addr_w1] <= rf.rf_data_w1;
                end
            end
        end
    end

    // Combinational read ports, each evaluated independently.
    always_comb begin
        rd1_s = read_sel(rf.rf_addr_r1, mem_q[rf.rf_addr_r1], ready_q,
                         we0_s, rf.rf_addr_w0, rf.rf_data_w0,
                         we1_s, rf.rf_addr_w1, rf.rf_data_w1);
        rd2_s = read_sel(rf.rf_addr_r2, mem_q[rf.rf_addr_r2], ready_q,
                         we0_s, rf.rf_addr_w0, rf.rf_data_w0,
                         we1_s, rf.rf_addr_w1, rf.rf_data_w1);
    end

    assign rf.rf_ready   = ready_q;
    assign rf.rf_data_r1 = rd1_s;
    assign rf.rf_data_r2 = rd2_s;
endmodule

// File: tb/tb_rf_multiport.sv
// Directed testbench for rf_multiport. It drives three builds:
//   ua: the default build.
//   ub: no bypass and no hardwired zero, driven in lockstep with ua.
//   uc: a small build with DATA_W=16 and ADDR_W=3, checked at the end.
module tb_rf_multiport;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_c = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] model_c [8];

    always #5 clk = ~clk;

    rf_multiport_if #(.DATA_W(32), .ADDR_W(5)) ifa ();
    rf_multiport_if #(.DATA_W(32), .ADDR_W(5)) ifb ();
    rf_multiport_if #(.DATA_W(16), .ADDR_W(3)) ifc ();

    rf_multiport #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1))
        ua (.clk(clk), .rst(rst), .rf(ifa));
    rf_multiport #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b0), .BYPASS(1'b0))
        ub (.clk(clk), .rst(rst), .rf(ifb));
    rf_multiport #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b1), .BYPASS(1'b1))
        uc (.clk(clk), .rst(rst_c), .rf(ifc));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic [4:0] r1, input logic [4:0] r2);
        ifa.rf_wen0 = w0; ifa.rf_addr_w0 = a0; ifa.rf_data_w0 = d0;
        ifa.rf_wen1 = w1; ifa.rf_addr_w1 = a1; ifa.rf_data_w1 = d1;
        ifa.rf_addr_r1 = r1; ifa.rf_addr_r2 = r2;
        ifb.rf_wen0 = w0; ifb.rf_addr_w0 = a0; ifb.rf_data_w0 = d0;
        ifb.rf_wen1 = w1; ifb.rf_addr_w1 = a1; ifb.rf_data_w1 = d1;
        ifb.rf_addr_r1 = r1; ifb.rf_addr_r2 = r2;
    endtask

    task automatic set_clr(input logic c);
        ifa.clr_req = c;
        ifb.clr_req = c;
    endtask

    // Wait for ua to become ready.
    // Returns the number of edges seen, capped at 100.
    task automatic wait_ready(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!ifa.rf_ready && n < 100);
    endtask

    // Every address of ua and ub must read zero.
    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
            #1;
            check({tag, "_a_r1"}, ifa.rf_data_r1, 32'h0);
            check({tag, "_a_r2"}, ifa.rf_data_r2, 32'h0);
            check({tag, "_b_r1"}, ifb.rf_data_r1, 32'h0);
        end
    endtask

    initial begin
        int n;
        int nb;
        set_clr(1'b0);
        drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4);
        ifc.clr_req = 1'b0;
        ifc.rf_wen0 = 1'b0; ifc.rf_addr_w0 = 3'd0; ifc.rf_data_w0 = 16'h0;
        ifc.rf_wen1 = 1'b0; ifc.rf_addr_w1 = 3'd0; ifc.rf_data_w1 = 16'h0;
        ifc.rf_addr_r1 = 3'd0; ifc.rf_addr_r2 = 3'd0;

        // Reset held for two edges, then the 32-cycle sweep.
        tick();
        tick();
        check("rst_ready_a", 32'(ifa.rf_ready), 32'h0);
        check("rst_ready_b", 32'(ifb.rf_ready), 32'h0);
        check("rst_rd1_a", ifa.rf_data_r1, 32'h0);
        check("rst_rd2_b", ifb.rf_data_r2, 32'h0);
        rst = 1'b0;
        n = 0;
        nb = 0;
        do begin
            tick();
            n++;
            if (ifb.rf_ready && nb == 0) nb = n;
        end while (!ifa.rf_ready && n < 100);
        check("rst_sweep_len_a", 32'(n), 32'd32);
        check("rst_sweep_len_b", 32'(nb), 32'd32);
        check_all_zero("post_rst");

        // Both ports write address 5 in the same cycle.
        drv(1'b1, 5'd5, 32'h11111111, 1'b1, 5'd5, 32'h22222222, 5'd5, 5'd5);
        #1;
        check("conf_byp_a", ifa.rf_data_r1, 32'h22222222);
        check("conf_nobyp_b", ifb.rf_data_r1, 32'h0);
        tick();
        drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        #1;
        check("conf_store_a", ifa.rf_data_r1, 32'h22222222);
        check("conf_store_b", ifb.rf_data_r2, 32'h22222222);

        // Distinct addresses 6 and 7.
        drv(1'b1, 5'd6, 32'hA5A5A5A5, 1'b1, 5'd7, 32'h5A5A5A5A, 5'd6, 5'd7);
        #1;
        check("dist_byp0_a", ifa.rf_data_r1, 32'hA5A5A5A5);
        check("dist_byp1_a", ifa.rf_data_r2, 32'h5A5A5A5A);
        tick();
        drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd6, 5'd7);
        #1;
        check("dist_st6_a", ifa.rf_data_r1, 32'hA5A5A5A5);
        check("dist_st7_a", ifa.rf_data_r2, 32'h5A5A5A5A);
        check("dist_st6_b", ifb.rf_data_r1, 32'hA5A5A5A5);
        check("dist_st7_b", ifb.rf_data_r2, 32'h5A5A5A5A);

        // Bypass on read port 2.
        drv(1'b1, 5'd9, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 5'd5, 5'd9);
        #1;
        check("byp_same_a", ifa.rf_data_r2, 32'hDEADBEEF);
        check("byp_old_b", ifb.rf_data_r2, 32'h0);
        check("byp_other_a", ifa.rf_data_r1, 32'h22222222);
        tick();
        drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd9);
        #1;
        check("byp_next_b", ifb.rf_data_r2, 32'hDEADBEEF);
        check("byp_next_a", ifa.rf_data_r2, 32'hDEADBEEF);

        // Both ports write address 0.
        drv(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        #1;
        check("zero_same_a", ifa.rf_data_r1, 32'h0);
        check("zero_same_b", ifb.rf_data_r1, 32'h0);
        tick();
        drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        #1;
        check("zero_later_a", ifa.rf_data_r1, 32'h0);
        check("zero_later_b", ifb.rf_data_r2, 32'hFFFFFFFF);

        // A clear request with a same-cycle write.
        // Writes attempted during the sweep must be dropped.
        set_clr(1'b1);
        drv(1'b1, 5'd12, 32'h12345678, 1'b0, 5'd0, 32'h0, 5'd5, 5'd9);
        tick();
        set_clr(1'b0);
        drv(1'b1, 5'd3, 32'hCAFEF00D, 1'b1, 5'd31, 32'hBEEFCAFE, 5'd5, 5'd3);
        #1;
        check("clr_ready_low_a", 32'(ifa.rf_ready), 32'h0);
        check("clr_rd_zero_a", ifa.rf_data_r1, 32'h0);
        check("clr_rd_zero_b", ifb.rf_data_r1, 32'h0);
        check("clr_wr_nobyp_a", ifa.rf_data_r2, 32'h0);
        wait_ready(n);
        check("clr_sweep_len", 32'(n), 32'd32);
        check_all_zero("post_clr");

        // Reset asserted ten cycles into a sweep restarts the sweep.
        drv(1'b1, 5'd5, 32'h0BADF00D, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        tick();
        drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        #1;
        check("pre_rst_val_a", ifa.rf_data_r1, 32'h0BADF00D);
        set_clr(1'b1);
        tick();
        set_clr(1'b0);
        for (int i = 0; i < 10; i++) tick();
        check("mid_ready_low", 32'(ifa.rf_ready), 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_ready(n);
        check("mid_rst_len", 32'(n), 32'd32);
        #1;
        check("mid_rst_rd_a", ifa.rf_data_r1, 32'h0);

        // Small build with an 8-entry clear.
        // Write every entry, then check against the model.
        tick();
        rst_c = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!ifc.rf_ready && n < 100);
        check("c_sweep_len", 32'(n), 32'd8);
        for (int i = 0; i < 8; i++) begin
            logic [15:0] d;
            d = 16'($urandom_range(1, 65535));
            model_c[i] = (i == 0) ? 16'h0 : d;
            ifc.rf_wen0 = (i % 2 == 0);
            ifc.rf_wen1 = (i % 2 == 1);
            ifc.rf_addr_w0 = 3'(i); ifc.rf_data_w0 = d;
            ifc.rf_addr_w1 = 3'(i); ifc.rf_data_w1 = d;
            tick();
        end
        ifc.rf_wen0 = 1'b0;
        ifc.rf_wen1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ifc.rf_addr_r1 = 3'(i);
            ifc.rf_addr_r2 = 3'(7 - i);
            #1;
            check("c_rd1", 32'(ifc.rf_data_r1), 32'(model_c[i]));
            check("c_rd2", 32'(ifc.rf_data_r2), 32'(model_c[7 - i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
